// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: derives per-stage enable/flush/bubble controls from
// load-use, branch, MUL/DIV and data-memory wait conditions, with saturating perf counters.
module pipe_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mdu_timeout
);

    localparam int CW = $clog2(MDU_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_BUSY = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           r_ret_state;
    logic             r_done_seen;
    logic [CW-1:0]    r_mdu_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    state_t           w_state_nxt;
    state_t           w_ret_nxt;
    state_t           w_eff_state;
    logic             w_seen_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_timeout_nxt;
    logic             w_lu;
    logic             w_mem_stall;
    logic             w_pc_en;
    logic             w_ifid_en;
    logic             w_idex_en;
    logic             w_exmem_en;
    logic             w_memwb_en;
    logic             w_ifid_flush;
    logic             w_idex_flush;
    logic             w_exmem_bubble;

    assign w_lu = ex_memread && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign w_mem_stall = mem_req && !dmem_ready;
    // On the MEM_WAIT exit cycle the controller behaves as the state it interrupted.
    assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

    // Next-state and control-output decode, in hazard priority order.
    always_comb begin
        w_pc_en        = 1'b0;
        w_ifid_en      = 1'b0;
        w_idex_en      = 1'b0;
        w_exmem_en     = 1'b0;
        w_memwb_en     = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_bubble = 1'b0;
        w_state_nxt    = r_state;
        w_ret_nxt      = r_ret_state;
        w_seen_nxt     = r_done_seen;
        w_cnt_nxt      = r_mdu_cnt;
        w_timeout_nxt  = r_timeout;
        if (rst) begin
            w_state_nxt = ST_RUN;
        end else if (w_mem_stall) begin
            if (r_state != ST_MEM_WAIT) begin
                w_ret_nxt   = r_state;
                w_state_nxt = ST_MEM_WAIT;
            end else begin
                w_ret_nxt = r_ret_state;
            end
            if (mdu_done) begin
                w_seen_nxt = 1'b1;
            end else begin
                w_seen_nxt = r_done_seen;
            end
        end else begin
            case (w_eff_state)
                ST_RUN: begin
                    w_state_nxt = ST_RUN;
                    if (ex_branch_taken) begin
                        {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b11111;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (ex_mdu_start && !mdu_done) begin
                        w_exmem_en     = 1'b1;
                        w_memwb_en     = 1'b1;
                        w_exmem_bubble = 1'b1;
                        w_state_nxt    = ST_MDU_BUSY;
                        w_cnt_nxt      = CW'(1);
                    end else if (w_lu) begin
                        w_idex_en    = 1'b1;
                        w_idex_flush = 1'b1;
                        w_exmem_en   = 1'b1;
                        w_memwb_en   = 1'b1;
                    end else begin
                        {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b11111;
                    end
                end
                ST_MDU_BUSY: begin
                    if (mdu_done || r_done_seen) begin
                        {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b11111;
                        w_seen_nxt  = 1'b0;
                        w_state_nxt = ST_RUN;
                    end else if (r_mdu_cnt == CW'(MDU_TIMEOUT)) begin
                        // Abandon the stuck operation and let the pipeline drain.
                        {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b11111;
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = ST_RUN;
                    end else begin
                        w_exmem_en     = 1'b1;
                        w_memwb_en     = 1'b1;
                        w_exmem_bubble = 1'b1;
                        w_cnt_nxt      = r_mdu_cnt + CW'(1);
                        w_state_nxt    = ST_MDU_BUSY;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State, MDU bookkeeping and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_done_seen <= 1'b0;
            r_mdu_cnt   <= {CW{1'b0}};
            r_timeout   <= 1'b0;
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_done_seen <= w_seen_nxt;
            r_mdu_cnt   <= w_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
            if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_ifid_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign pc_en        = w_pc_en;
    assign ifid_en      = w_ifid_en;
    assign idex_en      = w_idex_en;
    assign exmem_en     = w_exmem_en;
    assign memwb_en     = w_memwb_en;
    assign ifid_flush   = w_ifid_flush;
    assign idex_flush   = w_idex_flush;
    assign exmem_bubble = w_exmem_bubble;
    assign state        = r_state;
    assign stall_count  = r_stall_cnt;
    assign flush_count  = r_flush_cnt;
    assign mdu_timeout  = r_timeout;

endmodule
